// File: rtl/mips_pkg.sv
// Shared definitions for the M-stage exception sequencer and its CP0 neighbours.
package mips_pkg;

    // Sequencer states: normal execution, pipeline flush, fetch redirect.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } excState_t;

    // Default exception/interrupt entry point.
    localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;

    // CP0 register indices: Status, Cause, EPC.
    localparam int CP0_SR    = 12;
    localparam int CP0_CAUSE = 13;
    localparam int CP0_EPC   = 14;

    // Exception-code field width as seen by CP0.
    localparam int EXC_CODE_W = 5;

endpackage

// File: rtl/mips_int_sync.sv
// One interrupt line: multi-flop synchroniser followed by a rising-edge detector.
// intPulse is high for exactly one cycle per 0->1 transition seen at the
// synchroniser output.
module mips_int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic intRaw,
    output logic intPulse
);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   prevReg;

    // Shift the raw line through the chain and remember the last synced value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncReg <= '0;
            prevReg <= 1'b0;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], intRaw};
            prevReg <= syncReg[SYNC_STAGES-1];
        end
    end

    assign intPulse = syncReg[SYNC_STAGES-1] & ~prevReg;

endmodule

// File: rtl/mips_exc_ctrl.sv
// Exception/interrupt sequencer between the M stage and CP0.
// Holds synchronised interrupt pending bits, gates M-stage exception codes into
// CP0, and on a CP0 request or an accepted ERET runs flush -> redirect.
module mips_exc_ctrl
    import mips_pkg::*;
#(
    parameter int          NUM_INT      = 6,
    parameter int          SYNC_STAGES  = 2,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INT-1:0]    intRaw,
    input  logic [NUM_INT-1:0]    intAck,
    input  logic                  validM,
    input  logic [EXC_CODE_W-1:0] excCodeM,
    input  logic [31:0]           pcM,
    input  logic                  bdM,
    input  logic                  eretM,
    input  logic [31:0]           epcIn,
    input  logic                  cp0Req,
    output logic [NUM_INT-1:0]    hwInt,
    output logic [EXC_CODE_W-1:0] excCodeOut,
    output logic [31:0]           pcOut,
    output logic                  bdOut,
    output logic                  exlClr,
    output logic                  flush,
    output logic                  redirect,
    output logic [31:0]           redirectPC,
    output logic                  busy
);

    localparam int              CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    logic [NUM_INT-1:0] intPulse;
    logic [NUM_INT-1:0] pendingReg;

    excState_t          stateReg;
    logic [CNT_W-1:0]   cntReg;
    logic [31:0]        targetReg;
    logic               flushReg;
    logic               redirectReg;
    logic [31:0]        redirectPCReg;
    logic               busyReg;

    logic               runState;
    logic               eretAccept;

    generate
        for (genvar gi = 0; gi < NUM_INT; gi++) begin : gIntSync
            mips_int_sync #(
                .SYNC_STAGES(SYNC_STAGES)
            ) uIntSync (
                .clk     (clk),
                .reset   (reset),
                .intRaw  (intRaw[gi]),
                .intPulse(intPulse[gi])
            );
        end
    endgenerate

    // Pending bits: handler acks clear, a fresh edge sets; the set wins a tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pendingReg <= '0;
        end else begin
            pendingReg <= (pendingReg & ~intAck) | intPulse;
        end
    end

    assign hwInt = pendingReg;

    // Triggers are only honoured in RUN; CP0 requests take priority over ERET.
    assign runState   = (stateReg == ST_RUN);
    assign eretAccept = runState && eretM && validM && (excCodeM == '0) && !cp0Req;
    assign exlClr     = eretAccept;
    assign excCodeOut = (runState && validM) ? excCodeM : '0;
    assign pcOut      = pcM;
    assign bdOut      = bdM;

    // Sequencer with its outputs registered alongside the state so they never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg      <= ST_RUN;
            cntReg        <= '0;
            targetReg     <= '0;
            flushReg      <= 1'b0;
            redirectReg   <= 1'b0;
            redirectPCReg <= '0;
            busyReg       <= 1'b0;
        end else begin
            case (stateReg)
                ST_RUN: begin
                    flushReg      <= 1'b0;
                    redirectReg   <= 1'b0;
                    redirectPCReg <= '0;
                    busyReg       <= 1'b0;
                    if (cp0Req) begin
                        targetReg <= HANDLER_ADDR;
                        cntReg    <= CNT_INIT;
                        stateReg  <= ST_FLUSH;
                        flushReg  <= 1'b1;
                        busyReg   <= 1'b1;
                    end else if (eretAccept) begin
                        targetReg <= epcIn;
                        cntReg    <= CNT_INIT;
                        stateReg  <= ST_FLUSH;
                        flushReg  <= 1'b1;
                        busyReg   <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flushReg <= 1'b1;
                    busyReg  <= 1'b1;
                    if (cntReg == '0) begin
                        stateReg      <= ST_REDIR;
                        redirectReg   <= 1'b1;
                        redirectPCReg <= targetReg;
                    end else begin
                        cntReg <= cntReg - CNT_W'(1);
                    end
                end
                ST_REDIR: begin
                    stateReg      <= ST_RUN;
                    flushReg      <= 1'b0;
                    redirectReg   <= 1'b0;
                    redirectPCReg <= '0;
                    busyReg       <= 1'b0;
                end
                default: begin
                    stateReg      <= ST_RUN;
                    flushReg      <= 1'b0;
                    redirectReg   <= 1'b0;
                    redirectPCReg <= '0;
                    busyReg       <= 1'b0;
                end
            endcase
        end
    end

    assign flush      = flushReg;
    assign redirect   = redirectReg;
    assign redirectPC = redirectPCReg;
    assign busy       = busyReg;

endmodule
